intarb_level: RTL
=================

Name: intarb_level

Overview:
- Per-level interrupt source arbiter, directly upstream of the single-level BR/BG interrupt controller.
- Collects up to NREQ device interrupt requests sharing one BR level and selects one winner.
- Drives the controller's intvec input and holds it stable through the whole bus-request, grant, SACK and INTR sequence.
- Watches the controller's outputs and returns a one-cycle ack to the device whose vector was delivered.

Parameters:
NREQ, 4, number of request sources at this level (1..8); index 0 has highest fixed priority.

Ports:
CLOCK  input  1  system clock.
RESET  input  1  asynchronous, active-high reset; includes bus init.
req  input  NREQ  per-source interrupt request, level, active-high.
vec  input  8*NREQ  per-source vector; source i occupies vec[8*i+7:8*i]; bits [1:0] ignored.
br_out_h  input  1  controller bus request output.
sack_out_h  input  1  controller SACK output.
intr_out_h  input  1  controller INTR output.
intvec  output  8  to controller; 8'h01 = nothing requested, else {vec[7:2],2'b00}.
ack  output  NREQ  one-cycle pulse to the source whose vector was delivered.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous): intvec=8'h01, ack=0, busy=0, sel=0, state=IDLE. RESET mid-sequence aborts it with no ack.
- All outputs are registered.
- IDLE: intvec=8'h01.
  - If any req bit is set, pick the lowest set index, register it as sel, and register intvec={vec[sel][7:2],2'b00}. Go to OFFER.
  - intvec therefore appears 1 cycle after req is sampled.
- OFFER:
  - br_out_h or sack_out_h sampled high -> LOCKED.
  - req[sel] low -> intvec<=8'h01, go to IDLE.
  - sel and intvec are frozen in OFFER; a newly raised higher-priority request does not preempt.
- LOCKED:
  - intr_out_h high -> DELIVER.
  - Otherwise, req[sel] low -> intvec<=8'h01, go to CANCEL.
  - If both hold in the same cycle, intr_out_h wins and the interrupt is delivered.
- CANCEL: intvec=8'h01. Wait until br_out_h, sack_out_h and intr_out_h are all low, then go to IDLE.
  - The controller completes grant and SACK, then drops them without INTR.
- DELIVER: intvec is held.
  - When intr_out_h falls (high on the previous cycle, low now): ack[sel]<=1 for exactly one cycle, intvec<=8'h01, go to HOLDOFF.
- HOLDOFF: one cycle with ack=0 and intvec=8'h01, then go to IDLE.
  - This gives the source one cycle to drop req after ack, preventing a double interrupt.
- vec[sel] is sampled only on IDLE->OFFER. Later changes to vec are ignored until the next arbitration.
- No two ack bits are ever high together.
- ack never pulses for a cancelled request.
- busy is high in every state except IDLE.
- Sources whose req is held high continuously are serviced back to back, each separated by the HOLDOFF cycle.
- Only indices 0..NREQ-1 exist; no wrap-around beyond NREQ-1.

Optional Feature:
INTARB_ROUNDROBIN_EN
- Defined:
  - A registered pointer last is initialised to NREQ-1 on reset.
  - IDLE picks the first set req searching upward from last+1, modulo NREQ.
  - last<=sel when ack is issued.
  - Cancelled requests do not update last.
- Undefined: fixed priority, lowest index wins. No pointer register exists.

Decomposition:
- Shared package intarb_pkg:
  - INTVEC_NONE=8'h01.
  - State enum IDLE, OFFER, LOCKED, CANCEL, DELIVER, HOLDOFF (3-bit encoding).
  - NREQ_MAX=8.
- One sub-module intarb_pick:
  - Purely combinational: req and start index in; found flag and winner index out.
  - Used in both fixed-priority and round-robin modes; fixed mode ties start to 0.

Test Plan:
- Reset with req=4'b0000 -> intvec=8'h01, ack=0, busy=0. Assert RESET mid-DELIVER -> intvec=8'h01 immediately (asynchronous), no ack.
- req=4'b0100, vec[2]=8'o063 -> intvec=8'h30 one cycle later. Model br, then sack, then intr high for 3 cycles, then low -> ack=4'b0100 for 1 cycle, intvec=8'h01, next arbitration no sooner than 2 cycles after intr falls.
- req=4'b1010 simultaneously (fixed priority) -> sel=1, its vector offered. After delivery with req[1] dropped on ack -> source 3 is offered next.
- Source 0 in LOCKED (sack high), req[0] drops -> intvec=8'h01 next cycle, state CANCEL, busy stays high until br, sack and intr all low, no ack issued.
- req[2] and intr_out_h both high in LOCKED while req[2] falls the same cycle -> DELIVER wins, ack[2] pulses once.
- With INTARB_ROUNDROBIN_EN, req=4'b1111 held high -> ack order 0,1,2,3,0; without the macro -> 0,0,0.

Source files
------------

// File: rtl/intarb_pkg.sv
// Shared definitions for the per-level interrupt source arbiter.
// Holds the "no request" vector code, the arbiter state encoding and the
// maximum number of sources a single BR level may carry.
package intarb_pkg;

  localparam logic [7:0] INTVEC_NONE = 8'h01;
  localparam int         NREQ_MAX    = 8;
  localparam int         IDXW        = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OFFER   = 3'd1,
    LOCKED  = 3'd2,
    CANCEL  = 3'd3,
    DELIVER = 3'd4,
    HOLDOFF = 3'd5
  } state_t;

endpackage

// File: rtl/intarb_level_if.sv
// Bundle between the device request sources, the single-level BR/BG
// interrupt controller and the arbiter. The master modport is the arbiter's
// view; the slave modport is the view of the surrounding sources/controller.
interface intarb_level_if #(parameter int NREQ = 4);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] vec;
  logic              br_out_h;
  logic              sack_out_h;
  logic              intr_out_h;
  logic [7:0]        intvec;
  logic [NREQ-1:0]   ack;
  logic              busy;

  modport master (
    input  req, vec, br_out_h, sack_out_h, intr_out_h,
    output intvec, ack, busy
  );

  modport slave (
    output req, vec, br_out_h, sack_out_h, intr_out_h,
    input  intvec, ack, busy
  );

endinterface

// File: rtl/intarb_pick.sv
// Combinational winner search: scans req upward from the start index,
// wrapping at NREQ-1, and reports the first set bit. A start of 0 gives
// plain fixed priority with index 0 highest.
module intarb_pick
  import intarb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] start,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  int pos;

  // Walk the candidates from farthest to nearest so the nearest set bit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos]) begin
        found = 1'b1;
        idx   = IDXW'(pos);
      end
    end
  end

endmodule

// File: rtl/intarb_level.sv
// Per-level interrupt source arbiter sitting in front of the single-level
// BR/BG interrupt controller. Chooses one requesting source, holds its vector
// on intvec for the whole BR/grant/SACK/INTR sequence and pulses ack to that
// source once the controller has delivered the vector.
// Optional macro INTARB_ROUNDROBIN_EN switches fixed priority to round-robin.
module intarb_level
  import intarb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  intarb_level_if.master   bus
);

  state_t          state;
  logic [IDXW-1:0] sel;
  logic            intr_q;

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] start;
  logic [7:0]      win_vec;
  logic            req_sel;
  logic [NREQ-1:0] sel_onehot;

`ifdef INTARB_ROUNDROBIN_EN
  logic [IDXW-1:0] last;
  assign start = (last == IDXW'(NREQ - 1)) ? '0 : last + 1'b1;
`else
  assign start = '0;
`endif

  intarb_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Extract the candidate's vector and the selected source's request/ack bit
  always_comb begin
    win_vec    = '0;
    req_sel    = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDXW'(i)) win_vec = bus.vec[8*i +: 8];
      if (sel == IDXW'(i)) begin
        req_sel       = bus.req[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Arbitration FSM; every output is registered alongside the state
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      sel        <= '0;
      intr_q     <= 1'b0;
      bus.intvec <= INTVEC_NONE;
      bus.ack    <= '0;
      bus.busy   <= 1'b0;
`ifdef INTARB_ROUNDROBIN_EN
      last       <= IDXW'(NREQ - 1);
`endif
    end else begin
      bus.ack <= '0;
      intr_q  <= bus.intr_out_h;
      case (state)
        IDLE: begin
          if (pick_found) begin
            sel        <= pick_idx;
            bus.intvec <= {win_vec[7:2], 2'b00};
            bus.busy   <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (bus.br_out_h || bus.sack_out_h) begin
            state <= LOCKED;
          end else if (!req_sel) begin
            bus.intvec <= INTVEC_NONE;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        LOCKED: begin
          if (bus.intr_out_h) begin
            state <= DELIVER;
          end else if (!req_sel) begin
            bus.intvec <= INTVEC_NONE;
            state      <= CANCEL;
          end
        end
        CANCEL: begin
          if (!bus.br_out_h && !bus.sack_out_h && !bus.intr_out_h) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        DELIVER: begin
          if (intr_q && !bus.intr_out_h) begin
            bus.ack    <= sel_onehot;
            bus.intvec <= INTVEC_NONE;
            state      <= HOLDOFF;
`ifdef INTARB_ROUNDROBIN_EN
            last       <= sel;
`endif
          end
        end
        HOLDOFF: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.intvec <= INTVEC_NONE;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
